csr_mgmt_bank: RTL and testbench

Parametrised host CSR bank for the Root Complex, next generation of the single-scratch CSR block. Provides `NUM_SCRATCH` host-visible scratch words, plus a command/status engine. The engine converts host CSR writes into handshaked PCIe `cfg_mgmt` configuration-space accesses, with completion timeout and captured read data. It sits between the host CSR port and the PCIe core's `cfg_mgmt` interface.

---
 rtl/csr_pkg.sv | 29 ++
 rtl/cfg_mgmt_seq.sv | 121 ++++++++++++
 rtl/csr_mgmt_bank.sv | 111 +++++++++++
 tb/tb_csr_mgmt_bank.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared register map, CMD/STATUS field positions and sequencer state type
// for the host CSR bank and its cfg_mgmt sequencer.
package csr_pkg;

   localparam logic [31:0] CSR_CMD_IDX    = 32'h100;
   localparam logic [31:0] CSR_STATUS_IDX = 32'h101;

   // CMD word layout
   localparam int CMD_WDATA_LSB = 0;
   localparam int CMD_ADDR_LSB  = 32;
   localparam int CMD_BE_LSB    = 64;
   localparam int CMD_WRITE_BIT = 68;
   localparam int CMD_TYPE1_BIT = 69;
   localparam int CMD_W         = 70;

   // STATUS word layout
   localparam int ST_BUSY_BIT    = 0;
   localparam int ST_DONE_BIT    = 1;
   localparam int ST_TIMEOUT_BIT = 2;
   localparam int ST_DROP_BIT    = 3;
   localparam int ST_LNK_BIT     = 4;
   localparam int ST_RDATA_LSB   = 32;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_WAIT = 1'b1
   } seq_state_t;

endpackage

// File: rtl/cfg_mgmt_seq.sv
// Turns an accepted CMD word into a level cfg_mgmt request held until the
// core's done pulse or a completion timeout; keeps the sticky status flags.
module cfg_mgmt_seq
   import csr_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [CMD_W-1:0] cmd,
   input  logic             status_clr,
   input  logic [31:0]      rd_data_in,
   input  logic             rw_done,
   output logic             req_read,
   output logic             req_write,
   output logic [31:0]      req_addr,
   output logic [31:0]      req_wdata,
   output logic [3:0]       req_be,
   output logic             req_type1,
   output logic             busy,
   output logic             done_flag,
   output logic             timeout_flag,
   output logic             drop_flag,
   output logic [31:0]      last_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   seq_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             req_read_next, req_write_next, req_type1_next;
   logic [31:0]      req_addr_next, req_wdata_next, last_rdata_next;
   logic [3:0]       req_be_next;
   logic             done_set, timeout_set, drop_set;

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      req_read_next   = req_read;
      req_write_next  = req_write;
      req_addr_next   = req_addr;
      req_wdata_next  = req_wdata;
      req_be_next     = req_be;
      req_type1_next  = req_type1;
      last_rdata_next = last_rdata;
      done_set        = 1'b0;
      timeout_set     = 1'b0;
      drop_set        = 1'b0;
      case (state_reg)
         SEQ_IDLE: begin
            if (cmd_valid) begin
               req_wdata_next = cmd[CMD_WDATA_LSB +: 32];
               req_addr_next  = cmd[CMD_ADDR_LSB +: 32];
               req_be_next    = cmd[CMD_BE_LSB +: 4];
               req_type1_next = cmd[CMD_TYPE1_BIT];
               req_write_next = cmd[CMD_WRITE_BIT];
               req_read_next  = ~cmd[CMD_WRITE_BIT];
               cnt_next       = '0;
               state_next     = SEQ_WAIT;
            end
         end
         SEQ_WAIT: begin
            drop_set = cmd_valid;
            // A done arriving on the final counted cycle still counts as done.
            if (rw_done) begin
               if (req_read) begin
                  last_rdata_next = rd_data_in;
               end
               req_read_next  = 1'b0;
               req_write_next = 1'b0;
               done_set       = 1'b1;
               state_next     = SEQ_IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               req_read_next  = 1'b0;
               req_write_next = 1'b0;
               timeout_set    = 1'b1;
               state_next     = SEQ_IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= SEQ_IDLE;
         cnt_reg      <= '0;
         req_read     <= 1'b0;
         req_write    <= 1'b0;
         req_addr     <= '0;
         req_wdata    <= '0;
         req_be       <= '0;
         req_type1    <= 1'b0;
         last_rdata   <= '0;
         done_flag    <= 1'b0;
         timeout_flag <= 1'b0;
         drop_flag    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         req_read     <= req_read_next;
         req_write    <= req_write_next;
         req_addr     <= req_addr_next;
         req_wdata    <= req_wdata_next;
         req_be       <= req_be_next;
         req_type1    <= req_type1_next;
         last_rdata   <= last_rdata_next;
         // Sticky flags: a set in the same cycle as a clearing read wins.
         done_flag    <= (done_flag & ~status_clr) | done_set;
         timeout_flag <= (timeout_flag & ~status_clr) | timeout_set;
         drop_flag    <= (drop_flag & ~status_clr) | drop_set;
      end
   end

   assign busy = (state_reg == SEQ_WAIT);

endmodule

// File: rtl/csr_mgmt_bank.sv
// Host CSR bank: scratch words, CMD/STATUS decode and registered read port
// in front of the cfg_mgmt sequencer.
module csr_mgmt_bank
   import csr_pkg::*;
#(
   parameter int DATA_W      = 512,
   parameter int NUM_SCRATCH = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              user_clk,
   input  logic              user_reset,
   input  logic              user_lnk_up,
   input  logic              h2f_csr_read,
   input  logic              h2f_csr_write,
   input  logic [31:0]       h2f_csr_addr,
   input  logic [DATA_W-1:0] h2f_csr_wrData,
   output logic [DATA_W-1:0] f2h_csr_rdData,
   output logic              f2h_csr_rdValid,
   output logic              csr_cfg_mgmt_read,
   output logic              csr_cfg_mgmt_write,
   output logic [31:0]       csr_cfg_mgmt_addr,
   output logic [31:0]       csr_cfg_mgmt_write_data,
   output logic [3:0]        csr_cfg_mgmt_byte_enable,
   output logic              csr_cfg_mgmt_type1_cfg_reg_access,
   input  logic [31:0]       cfg_mgmt_read_data,
   input  logic              cfg_mgmt_read_write_done
);

   logic [DATA_W-1:0]      scratch_reg [NUM_SCRATCH];
   logic [NUM_SCRATCH-1:0] scratch_we;
   logic [DATA_W-1:0]      rd_mux;
   logic                   host_wr, cmd_valid, status_clr;
   logic                   busy, done_flag, timeout_flag, drop_flag;
   logic [31:0]            last_rdata;

   // Simultaneous read and write: the write is discarded.
   assign host_wr    = h2f_csr_write & ~h2f_csr_read;
   assign cmd_valid  = host_wr && (h2f_csr_addr == CSR_CMD_IDX);
   assign status_clr = h2f_csr_read && (h2f_csr_addr == CSR_STATUS_IDX);

   for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch_we
      assign scratch_we[gi] = host_wr && (h2f_csr_addr == 32'(gi));
   end

   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (scratch_we[i]) begin
               scratch_reg[i] <= h2f_csr_wrData;
            end
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (h2f_csr_addr == 32'(i)) begin
            rd_mux = scratch_reg[i];
         end
      end
      if (h2f_csr_addr == CSR_STATUS_IDX) begin
         rd_mux[ST_BUSY_BIT]         = busy;
         rd_mux[ST_DONE_BIT]         = done_flag;
         rd_mux[ST_TIMEOUT_BIT]      = timeout_flag;
         rd_mux[ST_DROP_BIT]         = drop_flag;
         rd_mux[ST_LNK_BIT]          = user_lnk_up;
         rd_mux[ST_RDATA_LSB +: 32]  = last_rdata;
      end
   end

   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         f2h_csr_rdValid <= 1'b0;
         f2h_csr_rdData  <= '0;
      end else begin
         f2h_csr_rdValid <= h2f_csr_read;
         if (h2f_csr_read) begin
            f2h_csr_rdData <= rd_mux;
         end
      end
   end

   cfg_mgmt_seq #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_seq (
      .clk          (user_clk),
      .rst          (user_reset),
      .cmd_valid    (cmd_valid),
      .cmd          (h2f_csr_wrData[CMD_W-1:0]),
      .status_clr   (status_clr),
      .rd_data_in   (cfg_mgmt_read_data),
      .rw_done      (cfg_mgmt_read_write_done),
      .req_read     (csr_cfg_mgmt_read),
      .req_write    (csr_cfg_mgmt_write),
      .req_addr     (csr_cfg_mgmt_addr),
      .req_wdata    (csr_cfg_mgmt_write_data),
      .req_be       (csr_cfg_mgmt_byte_enable),
      .req_type1    (csr_cfg_mgmt_type1_cfg_reg_access),
      .busy         (busy),
      .done_flag    (done_flag),
      .timeout_flag (timeout_flag),
      .drop_flag    (drop_flag),
      .last_rdata   (last_rdata)
   );

endmodule

// File: tb/tb_csr_mgmt_bank.sv
// Self-checking bench for csr_mgmt_bank: vector table, randomized scratch
// traffic against a reference model, and cfg_mgmt command sequences.
module tb_csr_mgmt_bank;

   localparam int DW = 512;
   localparam int NS = 4;
   localparam int TO = 16;
   localparam logic [31:0] CMD_A  = 32'h100;
   localparam logic [31:0] STAT_A = 32'h101;

   logic          clk = 1'b0;
   logic          user_reset, user_lnk_up, rd, wr;
   logic [31:0]   addr;
   logic [DW-1:0] wdat;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          c_read, c_write, c_type1;
   logic [31:0]   c_addr, c_wdata, c_rdata;
   logic [3:0]    c_be;
   logic          c_done;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [DW-1:0] m_scr [NS];
   bit            m_done, m_to, m_drop;
   logic [31:0]   m_last;

   typedef struct {
      bit            is_wr;
      logic [31:0]   a;
      logic [DW-1:0] data;
      logic [DW-1:0] exp;
   } vec_t;
   vec_t vecs [10];

   logic [DW-1:0] d;
   int            hi;

   csr_mgmt_bank #(
      .DATA_W      (DW),
      .NUM_SCRATCH (NS),
      .TIMEOUT_CYC (TO)
   ) dut (
      .user_clk                          (clk),
      .user_reset                        (user_reset),
      .user_lnk_up                       (user_lnk_up),
      .h2f_csr_read                      (rd),
      .h2f_csr_write                     (wr),
      .h2f_csr_addr                      (addr),
      .h2f_csr_wrData                    (wdat),
      .f2h_csr_rdData                    (rdata),
      .f2h_csr_rdValid                   (rvalid),
      .csr_cfg_mgmt_read                 (c_read),
      .csr_cfg_mgmt_write                (c_write),
      .csr_cfg_mgmt_addr                 (c_addr),
      .csr_cfg_mgmt_write_data           (c_wdata),
      .csr_cfg_mgmt_byte_enable          (c_be),
      .csr_cfg_mgmt_type1_cfg_reg_access (c_type1),
      .cfg_mgmt_read_data                (c_rdata),
      .cfg_mgmt_read_write_done          (c_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] exp_status(input bit busy);
      logic [DW-1:0] v;
      v        = '0;
      v[0]     = busy;
      v[1]     = m_done;
      v[2]     = m_to;
      v[3]     = m_drop;
      v[4]     = user_lnk_up;
      v[63:32] = m_last;
      return v;
   endfunction

   function automatic logic [DW-1:0] cmd_word(input bit is_wr, input bit t1, input logic [3:0] be,
                                              input logic [31:0] a, input logic [31:0] wd);
      logic [DW-1:0] v;
      v        = '0;
      v[31:0]  = wd;
      v[63:32] = a;
      v[67:64] = be;
      v[68]    = is_wr;
      v[69]    = t1;
      return v;
   endfunction

   task automatic host_write(input logic [31:0] a, input logic [DW-1:0] data);
      wr = 1'b1; addr = a; wdat = data;
      tick();
      wr = 1'b0;
      $display("write idx=%0h", a);
   endtask

   task automatic host_read(input logic [31:0] a, output logic [DW-1:0] data);
      rd = 1'b1; addr = a;
      tick();
      rd = 1'b0;
      check("rd_valid", rvalid, 1);
      data = rdata;
      $display("read  idx=%0h data[63:0]=%0h", a, rdata[63:0]);
   endtask

   task automatic check_cfg_zero(input string name);
      check(name, {c_read, c_write, c_type1, c_be, c_addr, c_wdata}, '0);
   endtask

   initial begin
      user_reset = 1'b1; user_lnk_up = 1'b1; rd = 1'b0; wr = 1'b0;
      addr = '0; wdat = '0; c_rdata = '0; c_done = 1'b0;
      for (int i = 0; i < NS; i++) m_scr[i] = '0;
      m_done = 0; m_to = 0; m_drop = 0; m_last = '0;

      vecs[0] = '{1'b1, 32'd3,     {64{8'hA5}}, '0};
      vecs[1] = '{1'b0, 32'd3,     '0,          {64{8'hA5}}};
      vecs[2] = '{1'b1, 32'h200,   {DW{1'b1}},  '0};
      vecs[3] = '{1'b0, 32'h200,   '0,          '0};
      vecs[4] = '{1'b0, 32'd0,     '0,          '0};
      vecs[5] = '{1'b0, 32'h100,   '0,          '0};
      vecs[6] = '{1'b1, 32'd1,     DW'(32'h1234), '0};
      vecs[7] = '{1'b0, 32'd1,     '0,          DW'(32'h1234)};
      vecs[8] = '{1'b0, 32'd4,     '0,          '0};
      vecs[9] = '{1'b0, 32'd3,     '0,          {64{8'hA5}}};

      // Reset state
      repeat (3) tick();
      check_cfg_zero("reset_cfg_outputs");
      check("reset_rdvalid", rvalid, 0);
      user_reset = 1'b0;
      tick();
      host_read(32'd0, d);
      check("reset_scratch0", d, '0);
      host_read(STAT_A, d);
      check("reset_status_lnk1", d, exp_status(0));
      user_lnk_up = 1'b0;
      host_read(STAT_A, d);
      check("reset_status_lnk0", d, exp_status(0));
      user_lnk_up = 1'b1;

      // Vector table
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].is_wr) begin
            host_write(vecs[i].a, vecs[i].data);
            if (vecs[i].a < NS) m_scr[vecs[i].a] = vecs[i].data;
         end else begin
            host_read(vecs[i].a, d);
            check($sformatf("vec%0d_idx%0h", i, vecs[i].a), d, vecs[i].exp);
         end
      end

      // Randomized scratch traffic vs model
      for (int it = 0; it < 150; it++) begin
         logic [31:0]   a;
         logic [DW-1:0] data, exp;
         int            mode;
         a = 32'($urandom_range(0, NS + 2));
         if (a == NS + 2) a = 32'h200;
         for (int w = 0; w < DW / 32; w++) data[w*32 +: 32] = $urandom;
         mode = $urandom_range(0, 2);
         rd = (mode != 1); wr = (mode != 0); addr = a; wdat = data;
         exp = (a < NS) ? m_scr[a] : '0;
         tick();
         rd = 1'b0; wr = 1'b0;
         $display("rand %0d mode=%0d idx=%0h", it, mode, a);
         if (mode == 1) begin
            check("rand_no_rdvalid", rvalid, 0);
            if (a < NS) m_scr[a] = data;
         end else begin
            check("rand_rdvalid", rvalid, 1);
            check($sformatf("rand_read_idx%0h", a), rdata, exp);
         end
      end

      // done pulse in IDLE must be ignored
      c_rdata = 32'hDEADBEEF;
      c_done = 1'b1; tick(); c_done = 1'b0;
      host_read(STAT_A, d);
      check("done_ignored_idle", d, exp_status(0));

      // CMD read, done after 5 request cycles
      host_write(CMD_A, cmd_word(0, 0, 4'hF, 32'h10, 32'h0));
      check("cmdrd_req", {c_read, c_write, c_type1, c_be, c_addr}, {1'b1, 1'b0, 1'b0, 4'hF, 32'h10});
      hi = 0;
      for (int c = 0; c < 40; c++) begin
         if (!c_read) break;
         hi++;
         if (hi == 5) c_done = 1'b1;
         tick();
         c_done = 1'b0;
      end
      check("cmdrd_req_cycles", hi, 5);
      m_done = 1; m_last = 32'hDEADBEEF;
      host_read(STAT_A, d);
      check("cmdrd_status_done", d, exp_status(0));
      m_done = 0;
      host_read(STAT_A, d);
      check("cmdrd_status_cleared", d, exp_status(0));

      // CMD write with no completion: timeout
      c_rdata = 32'h11111111;
      host_write(CMD_A, cmd_word(1, 1, 4'h3, 32'h20, 32'h12345678));
      check("cmdwr_req", {c_read, c_write, c_type1, c_be, c_addr, c_wdata},
            {1'b0, 1'b1, 1'b1, 4'h3, 32'h20, 32'h12345678});
      hi = 0;
      for (int c = 0; c < 100; c++) begin
         if (!c_write) break;
         hi++;
         tick();
      end
      check("timeout_req_cycles", hi, TO);
      m_to = 1;
      host_read(STAT_A, d);
      check("timeout_status", d, exp_status(0));
      m_to = 0;

      // Second CMD while busy; done coincides with a STATUS read
      c_rdata = 32'hCAFEF00D;
      host_write(CMD_A, cmd_word(0, 0, 4'hF, 32'h30, 32'h0));
      host_read(STAT_A, d);
      check("busy_after_cmd", d, exp_status(1));
      host_write(CMD_A, cmd_word(1, 0, 4'hF, 32'h40, 32'hAAAA));
      m_drop = 1;
      check("drop_req_unchanged", {c_read, c_write, c_addr}, {1'b1, 1'b0, 32'h30});
      rd = 1'b1; addr = STAT_A; c_done = 1'b1;
      tick();
      rd = 1'b0; c_done = 1'b0;
      check("clr_race_rdvalid", rvalid, 1);
      check("clr_race_preclear", rdata, exp_status(1));
      m_drop = 0; m_done = 1; m_last = 32'hCAFEF00D;
      check("drop_req_dropped", {c_read, c_write}, 2'b00);
      hi = 0;
      for (int c = 0; c < 20; c++) begin
         if (c_read || c_write) hi++;
         tick();
      end
      check("no_second_req", hi, 0);
      host_read(STAT_A, d);
      check("drop_status_setwins", d, exp_status(0));
      m_done = 0;

      // Reset mid-WAIT
      host_write(CMD_A, cmd_word(1, 1, 4'hF, 32'h50, 32'h55));
      tick(); tick();
      check("rst_pre_req", c_write, 1);
      #2 user_reset = 1'b1;
      #1;
      check_cfg_zero("rst_async_cfg");
      check("rst_async_rdvalid", rvalid, 0);
      #2 user_reset = 1'b0;
      for (int i = 0; i < NS; i++) m_scr[i] = '0;
      m_done = 0; m_to = 0; m_drop = 0; m_last = '0;
      tick();
      host_read(STAT_A, d);
      check("rst_status", d, exp_status(0));
      host_read(32'd3, d);
      check("rst_scratch3", d, m_scr[3]);
      check_cfg_zero("rst_cfg_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
